// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: Moore-style sequencing of a shared-memory datapath,
// with bounded memory waits, illegal-opcode trapping and debug counters.
module mips_multicycle_ctrl #(
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_write,
    output logic [1:0]       regdst,
    output logic [1:0]       memtoreg,
    output logic             alusrca,
    output logic [1:0]       alusrcb,
    output logic [1:0]       aluop,
    output logic [1:0]       pcsource,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] instr_count,
    output logic             illegal,
    output logic             mem_timeout
);

    typedef enum logic [3:0] {
        S_RST, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_REXEC,
        S_RWB, S_BEQ, S_ADDIEX, S_ADDIWB, S_JUMP, S_JAL, S_JR, S_TRAP
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] FN_JR    = 6'b001000;
    // Last wait count still tolerated; one more idle cycle means timeout.
    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    state_t     state_q, state_d;
    logic [7:0] wait_q;
    logic       in_mem_state;
    logic       timeout_hit;

    assign in_mem_state = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
    assign timeout_hit  = in_mem_state && !mem_ready && (wait_q == WAIT_LAST);

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RST:    state_d = S_FETCH;
            S_FETCH:  if (mem_ready) state_d = S_DECODE;
                      else if (timeout_hit) state_d = S_TRAP;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = (funct == FN_JR) ? S_JR : S_REXEC;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    OP_JAL:       state_d = S_JAL;
                    default:      state_d = S_TRAP;
                endcase
            end
            S_MEMADR: state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
                      else if (timeout_hit) state_d = S_TRAP;
            S_MEMWR:  if (mem_ready) state_d = S_FETCH;
                      else if (timeout_hit) state_d = S_TRAP;
            S_REXEC:  state_d = S_RWB;
            S_ADDIEX: state_d = S_ADDIWB;
            S_MEMWB, S_RWB, S_BEQ, S_ADDIWB, S_JUMP, S_JAL, S_JR: state_d = S_FETCH;
            S_TRAP:   state_d = S_TRAP;
            default:  state_d = S_TRAP;
        endcase
    end

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        regdst        = 2'b00;
        memtoreg      = 2'b00;
        alusrca       = 1'b0;
        alusrcb       = 2'b00;
        aluop         = 2'b00;
        pcsource      = 2'b00;
        case (state_q)
            S_FETCH: begin
                mem_read = 1'b1;
                alusrcb  = 2'b01;
                ir_write = mem_ready;
                pc_write = mem_ready;
            end
            S_DECODE: alusrcb = 2'b11;
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_MEMRD: begin
                iord     = 1'b1;
                mem_read = 1'b1;
            end
            S_MEMWB: begin
                reg_write = 1'b1;
                memtoreg  = 2'b01;
            end
            S_MEMWR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
            end
            S_REXEC: begin
                alusrca = 1'b1;
                aluop   = 2'b10;
            end
            S_RWB: begin
                reg_write = 1'b1;
                regdst    = 2'b01;
            end
            S_BEQ: begin
                alusrca       = 1'b1;
                aluop         = 2'b01;
                pcsource      = 2'b01;
                pc_write_cond = 1'b1;
            end
            S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_ADDIWB: reg_write = 1'b1;
            S_JUMP: begin
                pc_write = 1'b1;
                pcsource = 2'b10;
            end
            S_JAL: begin
                // PC already holds PC+4, so r31 receives the link address.
                pc_write  = 1'b1;
                pcsource  = 2'b10;
                reg_write = 1'b1;
                regdst    = 2'b10;
                memtoreg  = 2'b10;
            end
            S_JR: begin
                pc_write = 1'b1;
                pcsource = 2'b11;
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_RST;
            wait_q      <= '0;
            instr_count <= '0;
            illegal     <= 1'b0;
            mem_timeout <= 1'b0;
        end else begin
            state_q <= state_d;
            // Memory states only self-loop while waiting, so a hold is exactly a wait cycle.
            if (in_mem_state && (state_d == state_q)) wait_q <= wait_q + 8'd1;
            else                                      wait_q <= '0;
            if ((state_d == S_FETCH) && (state_q != S_FETCH) && (state_q != S_RST))
                instr_count <= instr_count + 1'b1;
            if ((state_q == S_DECODE) && (state_d == S_TRAP)) illegal <= 1'b1;
            if (timeout_hit) mem_timeout <= 1'b1;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Scoreboard bench: instruction-level driver predicts per-cycle state/controls,
// a negedge monitor pops and compares against the DUT.
module tb_mips_multicycle_ctrl;

    localparam int CNT_W = 4;

    localparam int RST = 0, FETCH = 1, DECODE = 2, MEMADR = 3, MEMRD = 4, MEMWB = 5,
                   MEMWR = 6, REXEC = 7, RWB = 8, BEQ = 9, ADDIEX = 10, ADDIWB = 11,
                   JUMP = 12, JAL = 13, JR = 14, TRAP = 15;

    localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                           OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010,
                           OP_JAL = 6'b000011, FN_JR = 6'b001000, FN_ADD = 6'b100000;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] regdst;
        logic [1:0] memtoreg;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic [1:0] pcsource;
    } ctrl_t;

    typedef struct packed {
        logic [3:0]       st;
        ctrl_t            c;
        logic [CNT_W-1:0] cnt;
        logic             ill;
        logic             mto;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic [5:0] opcode, funct;
    logic mem_ready;
    logic pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, reg_write, alusrca;
    logic [1:0] regdst, memtoreg, alusrcb, aluop, pcsource;
    logic [3:0] state;
    logic [CNT_W-1:0] instr_count;
    logic illegal, mem_timeout;
    ctrl_t dut_ctrl;

    mips_multicycle_ctrl #(.MAX_WAIT(16), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .reg_write(reg_write), .regdst(regdst), .memtoreg(memtoreg), .alusrca(alusrca),
        .alusrcb(alusrcb), .aluop(aluop), .pcsource(pcsource), .state(state),
        .instr_count(instr_count), .illegal(illegal), .mem_timeout(mem_timeout)
    );

    assign dut_ctrl = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, reg_write,
                       regdst, memtoreg, alusrca, alusrcb, aluop, pcsource};

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    exp_t exp_q[$];

    logic [CNT_W-1:0] m_cnt = '0;
    logic m_ill = 1'b0, m_mto = 1'b0, m_first = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Spec table: controls each state asserts (ready only matters in FETCH).
    function automatic ctrl_t ctl(input int st, input logic rdy);
        ctrl_t c = '0;
        case (st)
            FETCH:  begin c.mem_read = 1; c.alusrcb = 2'b01; c.ir_write = rdy; c.pc_write = rdy; end
            DECODE: c.alusrcb = 2'b11;
            MEMADR: begin c.alusrca = 1; c.alusrcb = 2'b10; end
            MEMRD:  begin c.iord = 1; c.mem_read = 1; end
            MEMWB:  begin c.reg_write = 1; c.memtoreg = 2'b01; end
            MEMWR:  begin c.iord = 1; c.mem_write = 1; end
            REXEC:  begin c.alusrca = 1; c.aluop = 2'b10; end
            RWB:    begin c.reg_write = 1; c.regdst = 2'b01; end
            BEQ:    begin c.alusrca = 1; c.aluop = 2'b01; c.pcsource = 2'b01; c.pc_write_cond = 1; end
            ADDIEX: begin c.alusrca = 1; c.alusrcb = 2'b10; end
            ADDIWB: c.reg_write = 1;
            JUMP:   begin c.pc_write = 1; c.pcsource = 2'b10; end
            JAL:    begin c.pc_write = 1; c.pcsource = 2'b10; c.reg_write = 1;
                          c.regdst = 2'b10; c.memtoreg = 2'b10; end
            JR:     begin c.pc_write = 1; c.pcsource = 2'b11; end
            default: ;
        endcase
        return c;
    endfunction

    // One clock cycle: drive mem_ready and record what the DUT must show this cycle.
    task automatic step(input int st, input logic rdy);
        exp_t e;
        @(posedge clk);
        #1;
        mem_ready = rdy;
        e.st  = 4'(st);
        e.c   = ctl(st, rdy);
        e.cnt = m_cnt;
        e.ill = m_ill;
        e.mto = m_mto;
        exp_q.push_back(e);
    endtask

    task automatic mem_phase(input int st, input int waits);
        for (int i = 0; i < waits; i++) step(st, 1'b0);
        step(st, 1'b1);
    endtask

    task automatic begin_fetch();
        if (!m_first) m_cnt = m_cnt + 1'b1;
        m_first = 1'b0;
    endtask

    function automatic logic rnd_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int fw, input int mw);
        begin_fetch();
        opcode = op;
        funct  = fn;
        mem_phase(FETCH, fw);
        step(DECODE, rnd_bit());
        case (op)
            OP_LW:   begin step(MEMADR, rnd_bit()); mem_phase(MEMRD, mw); step(MEMWB, rnd_bit()); end
            OP_SW:   begin step(MEMADR, rnd_bit()); mem_phase(MEMWR, mw); end
            OP_R:    if (fn == FN_JR) step(JR, rnd_bit());
                     else begin step(REXEC, rnd_bit()); step(RWB, rnd_bit()); end
            OP_BEQ:  step(BEQ, rnd_bit());
            OP_ADDI: begin step(ADDIEX, rnd_bit()); step(ADDIWB, rnd_bit()); end
            OP_J:    step(JUMP, rnd_bit());
            OP_JAL:  step(JAL, rnd_bit());
            default: begin m_ill = 1'b1; repeat (3) step(TRAP, rnd_bit()); end
        endcase
    endtask

    // Reset asserted between edges must take effect at once.
    task automatic async_reset_check(input string tag);
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check({tag, "_state"}, 32'(state), 32'd0);
        check({tag, "_ctrl"}, 32'(dut_ctrl), 32'd0);
        check({tag, "_flags"}, {30'd0, illegal, mem_timeout}, 32'd0);
        check({tag, "_count"}, 32'(instr_count), 32'd0);
        m_cnt = '0; m_ill = 1'b0; m_mto = 1'b0; m_first = 1'b1;
        step(RST, 1'b0);
        step(RST, 1'b1);
        reset = 1'b1;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("state", 32'(state), 32'(e.st));
            check("ctrl", 32'(dut_ctrl), 32'(e.c));
            check("instr_count", 32'(instr_count), 32'(e.cnt));
            check("flags", {30'd0, illegal, mem_timeout}, {30'd0, e.ill, e.mto});
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] ops [8];
        ops = '{OP_LW, OP_SW, OP_R, OP_R, OP_BEQ, OP_ADDI, OP_J, OP_JAL};
        reset = 1'b0; mem_ready = 1'b0; opcode = '0; funct = '0;

        step(RST, 1'b0);
        step(RST, 1'b1);
        reset = 1'b1;

        run_instr(OP_LW, 6'd0, 0, 0);
        run_instr(OP_R, FN_ADD, 0, 0);
        run_instr(OP_R, FN_JR, 0, 0);
        run_instr(OP_SW, 6'd0, 0, 3);
        run_instr(OP_JAL, 6'd0, 1, 0);
        run_instr(OP_BEQ, 6'd0, 2, 0);
        run_instr(OP_ADDI, 6'd0, 0, 0);
        run_instr(OP_LW, 6'd0, 15, 15);
        run_instr(OP_SW, 6'd0, 0, 15);
        for (int i = 0; i < 16; i++) run_instr(OP_J, 6'd0, 0, 0);

        for (int i = 0; i < 250; i++) begin
            logic [5:0] op, fn;
            int fw, mw;
            op = ops[$urandom_range(0, 7)];
            fn = 6'($urandom);
            if (op == OP_R && $urandom_range(0, 3) == 0) fn = FN_JR;
            fw = ($urandom_range(0, 19) == 0) ? $urandom_range(4, 15) : $urandom_range(0, 3);
            mw = ($urandom_range(0, 19) == 0) ? $urandom_range(4, 15) : $urandom_range(0, 3);
            run_instr(op, fn, fw, mw);
        end

        // Fetch never completes: 16 idle cycles, then TRAP with fetch requests dropped.
        begin_fetch();
        opcode = OP_LW;
        repeat (16) step(FETCH, 1'b0);
        m_mto = 1'b1;
        repeat (4) step(TRAP, rnd_bit());
        async_reset_check("timeout_reset");

        run_instr(OP_R, FN_ADD, 0, 0);
        run_instr(6'b111111, 6'd0, 0, 0);
        async_reset_check("illegal_reset");

        // Data read still waiting when reset hits.
        begin_fetch();
        opcode = OP_LW;
        step(FETCH, 1'b1);
        step(DECODE, 1'b0);
        step(MEMADR, 1'b0);
        step(MEMRD, 1'b0);
        async_reset_check("midinstr_reset");

        run_instr(OP_LW, 6'd0, 0, 1);
        run_instr(OP_J, 6'd0, 0, 0);
        run_instr(OP_SW, 6'd0, 1, 0);

        repeat (3) @(posedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
